// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor; WIDTH split into STAGES segments, one per register stage.
// Latency: STAGES cycles from accept to out_valid; one beat per cycle while out_ready is high.
// Backpressure: whole pipeline (data and valid, bubbles included) freezes while out_valid && !out_ready.
// Optional feature: define CLA_PIPE_SAT_EN to saturate Sum on signed overflow.
module cla_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int SEG = WIDTH / STAGES;
    localparam int GRP = SEG / 4;
    localparam int L   = STAGES - 1;

    // One segment built from 4-bit CLA groups; group carries chained through group P/G.
    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           cin);
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG-1:0] s;
        logic [GRP:0]   gc;
        logic [3:0]     gp;
        logic [3:0]     gg;
        logic [3:0]     c;
        logic           grp_g;
        logic           grp_p;
        p     = a ^ b;
        g     = a & b;
        s     = '0;
        gc    = '0;
        gc[0] = cin;
        for (int j = 0; j < GRP; j++) begin
            gp    = p[4*j +: 4];
            gg    = g[4*j +: 4];
            c[0]  = gc[j];
            c[1]  = gg[0] | (gp[0] & c[0]);
            c[2]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
            c[3]  = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                  | (gp[2] & gp[1] & gp[0] & c[0]);
            grp_g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                  | (gp[3] & gp[2] & gp[1] & gg[0]);
            grp_p = &gp;
            gc[j+1]      = grp_g | (grp_p & gc[j]);
            s[4*j +: 4]  = gp ^ c;
        end
        return {gc[GRP], s};
    endfunction

    // Stage registers: operands (skewed upper bits), partial sum, segment carry, valid.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];
    logic             ovf_q;
    logic             zero_q;

    // Per-stage inputs and results.
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic             c_in  [STAGES];
    logic             v_in  [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             nxt_c [STAGES];
    logic [WIDTH-1:0] fin_sum;
    logic             fin_ovf;
    logic             fin_zero;
    logic             advance;

    assign advance   = out_ready || !v_q[L];
    assign in_ready  = advance;
    assign out_valid = v_q[L];
    assign Sum       = s_q[L];
    assign Cout      = c_q[L];
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;

    // Stage inputs: stage 0 takes the ports (B inverted, carry forced to 1 when subtracting).
    always_comb begin
        a_in[0] = A;
        b_in[0] = sub ? ~B : B;
        c_in[0] = sub | Cin;
        s_in[0] = '0;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    // Each stage resolves exactly its own segment and merges it into the partial sum.
    always_comb begin
        logic [SEG:0] seg_r;
        seg_r = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg_r    = cla_seg(a_in[k][k*SEG +: SEG], b_in[k][k*SEG +: SEG], c_in[k]);
            nxt_s[k] = s_in[k];
            nxt_s[k][k*SEG +: SEG] = seg_r[SEG-1:0];
            nxt_c[k] = seg_r[SEG];
        end
    end

    // Final stage flags: signed overflow from operand/result signs, optional saturation, zero detect.
    always_comb begin
        fin_ovf = (a_in[L][WIDTH-1] == b_in[L][WIDTH-1]) &&
                  (nxt_s[L][WIDTH-1] != a_in[L][WIDTH-1]);
        fin_sum = nxt_s[L];
`ifdef CLA_PIPE_SAT_EN
        if (fin_ovf) begin
            fin_sum = a_in[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        fin_zero = (fin_sum == '0);
    end

    // Pipeline advance: everything moves together or everything holds; reset drops in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= nxt_s[k];
                c_q[k] <= nxt_c[k];
                v_q[k] <= v_in[k];
            end
            s_q[L] <= fin_sum;
            ovf_q  <= fin_ovf;
            zero_q <= fin_zero;
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and randomized bench for cla_pipe_addsub (WIDTH 32; STAGES 2 directed, STAGES 1/2/4 random).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Random traffic is scored against an arithmetic reference with per-instance expectation queues.
module tb_cla_pipe_addsub;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        sub;

    logic        in_ready1, out_valid1, Cout1, Ovf1, Zero1;
    logic        in_ready2, out_valid2, Cout2, Ovf2, Zero2;
    logic        in_ready4, out_valid4, Cout4, Ovf4, Zero4;
    logic [31:0] Sum1, Sum2, Sum4;

    int checks = 0;
    int errors = 0;
    bit sb_en  = 1'b0;

    logic [34:0] q1[$];
    logic [34:0] q2[$];
    logic [34:0] q4[$];

`ifdef CLA_PIPE_SAT_EN
    localparam logic [31:0] SUB_OVF_SUM = 32'h8000_0000;
    localparam logic [31:0] ADD_OVF_SUM = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] SUB_OVF_SUM = 32'h7FFF_FFFF;
    localparam logic [31:0] ADD_OVF_SUM = 32'h8000_0000;
`endif

    cla_pipe_addsub #(.WIDTH(32), .STAGES(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid2), .out_ready(out_ready),
        .Sum(Sum2), .Cout(Cout2), .Ovf(Ovf2), .Zero(Zero2));

    cla_pipe_addsub #(.WIDTH(32), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(out_ready),
        .Sum(Sum1), .Cout(Cout1), .Ovf(Ovf1), .Zero(Zero1));

    cla_pipe_addsub #(.WIDTH(32), .STAGES(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid4), .out_ready(out_ready),
        .Sum(Sum4), .Cout(Cout4), .Ovf(Ovf4), .Zero(Zero4));

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check35(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {ovf,zero,cout,sum}=%0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide addition, returns {ovf, zero, cout, sum}.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic sb);
        logic [31:0] bb;
        logic [32:0] r;
        logic [31:0] s;
        logic        ov;
        bb = sb ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {32'b0, (sb ? 1'b1 : ci)};
        s  = r[31:0];
        ov = (a[31] == bb[31]) && (s[31] != a[31]);
`ifdef CLA_PIPE_SAT_EN
        if (ov) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {ov, (s == 32'h0), r[32], s};
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            4:       v = 32'h0000_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // One isolated beat through the STAGES=2 instance with exact latency and flag checks.
    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb, input logic [31:0] es,
                          input logic ec, input logic eo, input logic ez);
        @(posedge clk); #1;
        in_valid = 1'b1; A = a; B = b; Cin = ci; sub = sb;
        @(posedge clk); #1;
        in_valid = 1'b0; A = $urandom; B = $urandom; Cin = 1'($urandom); sub = 1'($urandom);
        @(negedge clk);
        check1({tag, "_early"}, out_valid2, 1'b0);
        @(negedge clk);
        check1({tag, "_vld"}, out_valid2, 1'b1);
        check32({tag, "_sum"}, Sum2, es);
        check1({tag, "_cout"}, Cout2, ec);
        check1({tag, "_ovf"}, Ovf2, eo);
        check1({tag, "_zero"}, Zero2, ez);
    endtask

    // Scoreboards for random traffic, one per instance.
    always @(negedge clk) begin
        if (sb_en) begin
            if (rst) q1.delete();
            else begin
                if (out_valid1 && out_ready) begin
                    if (q1.size() == 0) check1("s1_unexpected", 1'b1, 1'b0);
                    else check35("s1_beat", {Ovf1, Zero1, Cout1, Sum1}, q1.pop_front());
                end
                if (in_valid && in_ready1) q1.push_back(model(A, B, Cin, sub));
            end
        end
    end

    always @(negedge clk) begin
        if (sb_en) begin
            if (rst) q2.delete();
            else begin
                if (out_valid2 && out_ready) begin
                    if (q2.size() == 0) check1("s2_unexpected", 1'b1, 1'b0);
                    else check35("s2_beat", {Ovf2, Zero2, Cout2, Sum2}, q2.pop_front());
                end
                if (in_valid && in_ready2) q2.push_back(model(A, B, Cin, sub));
            end
        end
    end

    always @(negedge clk) begin
        if (sb_en) begin
            if (rst) q4.delete();
            else begin
                if (out_valid4 && out_ready) begin
                    if (q4.size() == 0) check1("s4_unexpected", 1'b1, 1'b0);
                    else check35("s4_beat", {Ovf4, Zero4, Cout4, Sum4}, q4.pop_front());
                end
                if (in_valid && in_ready4) q4.push_back(model(A, B, Cin, sub));
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = 32'h0; B = 32'h0; Cin = 1'b0; sub = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("rst_out_valid", out_valid2, 1'b0);
        check32("rst_sum", Sum2, 32'h0);
        check1("rst_cout", Cout2, 1'b0);
        check1("rst_ovf", Ovf2, 1'b0);
        check1("rst_zero", Zero2, 1'b0);
        check1("rst_in_ready", in_ready2, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed single beats
        single("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, SUB_OVF_SUM,   1'b1, 1'b1, 1'b0);
        single("seg_carry",  32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0, 1'b0);
        single("sub_equal",  32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single("sub_borrow", 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        single("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, ADD_OVF_SUM,   1'b0, 1'b1, 1'b0);
        single("add_mixed",  32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0, 1'b0);

        // Back-to-back beats with a three-cycle stall after the first result
        @(posedge clk); #1;
        in_valid = 1'b1; A = 32'd1; B = 32'd1; Cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        A = 32'd2; B = 32'd2;
        @(posedge clk); #1;
        A = 32'd3; B = 32'd3; out_ready = 1'b0;
        @(negedge clk);
        check1("stall_vld0", out_valid2, 1'b1);
        check32("stall_sum0", Sum2, 32'd2);
        check1("stall_rdy0", in_ready2, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check1("stall_vld1", out_valid2, 1'b1);
        check32("stall_sum1", Sum2, 32'd2);
        check1("stall_rdy1", in_ready2, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check32("stall_sum2", Sum2, 32'd2);
        check1("stall_rdy2", in_ready2, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check1("stall_rdy3", in_ready2, 1'b1);
        check32("stall_sum3", Sum2, 32'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check1("b2b_vld4", out_valid2, 1'b1);
        check32("b2b_sum4", Sum2, 32'd4);
        @(posedge clk);
        @(negedge clk);
        check1("b2b_vld6", out_valid2, 1'b1);
        check32("b2b_sum6", Sum2, 32'd6);
        @(posedge clk);
        @(negedge clk);
        check1("b2b_empty", out_valid2, 1'b0);

        // Reset with two beats in flight
        @(posedge clk); #1;
        in_valid = 1'b1; A = 32'd10; B = 32'd1; Cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        A = 32'd20; B = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check1("pre_rst_vld", out_valid2, 1'b1);
        check32("pre_rst_sum", Sum2, 32'd11);
        @(posedge clk);
        @(negedge clk);
        check1("mid_rst_vld", out_valid2, 1'b0);
        check32("mid_rst_sum", Sum2, 32'h0);
        check1("mid_rst_rdy", in_ready2, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("post_rst_quiet", out_valid2, 1'b0);
            @(posedge clk);
        end
        single("after_rst", 32'd5, 32'd7, 1'b0, 1'b0, 32'd12, 1'b0, 1'b0, 1'b0);

        // Random add/sub with random stalls on all three depths
        @(posedge clk); #1;
        rst = 1'b1; sb_en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            A         = pick();
            B         = pick();
            Cin       = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check32("drain_s1", 32'(q1.size()), 32'd0);
        check32("drain_s2", 32'(q2.size()), 32'd0);
        check32("drain_s4", 32'(q4.size()), 32'd0);
        check1("drain_vld1", out_valid1, 1'b0);
        check1("drain_vld4", out_valid4, 1'b0);
        sb_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
